// File: rtl/vmem_pkg.sv
// Shared types and default sizing for the vector memory controller.
// Imported by the controller top and its round-robin arbiter.
package vmem_pkg;

    localparam int I_DEFAULT = 32;
    localparam int N_DEFAULT = 8;
    localparam int R_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE,
        VEC,
        VEC_LAST,
        DONE,
        HOST,
        HOST_RSP
    } vmem_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_HOST
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
// The history flag only moves on an enabled cycle that actually grants.
module rr_arbiter2
    import vmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic reqCpu,
    input  logic reqHost,
    output logic gntCpu,
    output logic gntHost
);

    grant_t lastGrantReg;

    always_comb begin
        gntCpu  = 1'b0;
        gntHost = 1'b0;
        if (enable) begin
            if (reqCpu && reqHost) begin
                if (lastGrantReg == GNT_HOST) gntCpu = 1'b1;
                else                          gntHost = 1'b1;
            end else if (reqCpu) begin
                gntCpu = 1'b1;
            end else if (reqHost) begin
                gntHost = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrantReg <= GNT_HOST;
        end else if (gntCpu) begin
            lastGrantReg <= GNT_CPU;
        end else if (gntHost) begin
            lastGrantReg <= GNT_HOST;
        end
    end

endmodule

// File: rtl/vmem_controller.sv
// Serialises R-lane vector loads/stores onto a byte-wide single-port RAM,
// stalling the pipeline meanwhile, and shares the RAM with a host loader.
module vmem_controller
    import vmem_pkg::*;
#(
    parameter int I = I_DEFAULT,
    parameter int N = N_DEFAULT,
    parameter int R = R_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemReqM,
    input  logic                MemWriteM,
    input  logic [I-1:0]        AddressM,
    input  logic [R-1:0][N-1:0] WriteDataM,
    output logic [R-1:0][N-1:0] ReadData,
    output logic                StallM,
    input  logic                HostReq,
    input  logic                HostWe,
    input  logic [I-1:0]        HostAddr,
    input  logic [N-1:0]        HostWData,
    output logic                HostGnt,
    output logic [N-1:0]        HostRData,
    output logic                HostValid,
    output logic [I-1:0]        RamAddr,
    output logic                RamWe,
    output logic [N-1:0]        RamWData,
    input  logic [N-1:0]        RamRData
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(R - 1);

    vmem_state_t   stateReg, stateNext;
    logic [CW-1:0] laneCntReg, laneCntNext;
    logic          arbEn, gntCpu, gntHost;
    logic          captureEn;
    logic [CW-1:0] captureIdx;
    logic          ramWeComb;
    logic [N-1:0]  laneReg [R];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (arbEn),
        .reqCpu (MemReqM),
        .reqHost(HostReq),
        .gntCpu (gntCpu),
        .gntHost(gntHost)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= IDLE;
            laneCntReg <= '0;
        end else begin
            stateReg   <= stateNext;
            laneCntReg <= laneCntNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        laneCntNext = laneCntReg;
        arbEn       = 1'b0;
        captureEn   = 1'b0;
        captureIdx  = '0;
        RamAddr     = '0;
        ramWeComb   = 1'b0;
        RamWData    = '0;
        HostGnt     = 1'b0;
        HostValid   = 1'b0;
        HostRData   = '0;
        case (stateReg)
            IDLE: begin
                arbEn       = 1'b1;
                laneCntNext = '0;
                if (gntCpu)       stateNext = VEC;
                else if (gntHost) stateNext = HOST;
            end
            VEC: begin
                RamAddr   = AddressM + I'(laneCntReg);
                ramWeComb = MemWriteM;
                RamWData  = WriteDataM[laneCntReg];
                // RAM data lags the address by one cycle, so lane k-1 lands now
                captureEn  = !MemWriteM && (laneCntReg != '0);
                captureIdx = laneCntReg - 1'b1;
                if (laneCntReg == LAST_LANE) stateNext = VEC_LAST;
                else                         laneCntNext = laneCntReg + 1'b1;
            end
            VEC_LAST: begin
                captureEn  = !MemWriteM;
                captureIdx = LAST_LANE;
                stateNext  = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            HOST: begin
                HostGnt   = 1'b1;
                RamAddr   = HostAddr;
                ramWeComb = HostWe;
                RamWData  = HostWData;
                stateNext = HostWe ? IDLE : HOST_RSP;
            end
            HOST_RSP: begin
                HostValid = 1'b1;
                HostRData = RamRData;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Masking with reset keeps an aborted store from writing the lane in flight.
    assign RamWe  = ramWeComb && !reset;
    assign StallM = MemReqM && (stateReg != DONE);

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (reset) begin
                    laneReg[gi] <= '0;
                end else if (captureEn && (captureIdx == CW'(gi))) begin
                    laneReg[gi] <= RamRData;
                end
            end
            assign ReadData[gi] = laneReg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_vmem_controller.sv
// Directed bench for vmem_controller with a behavioural byte RAM and
// hand-computed expectations for vector, host, arbitration and reset cases.
module tb_vmem_controller;

    localparam int I = 32;
    localparam int N = 8;
    localparam int R = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                MemReqM, MemWriteM;
    logic [I-1:0]        AddressM;
    logic [R-1:0][N-1:0] WriteDataM;
    logic [R-1:0][N-1:0] ReadData;
    logic                StallM;
    logic                HostReq, HostWe;
    logic [I-1:0]        HostAddr;
    logic [N-1:0]        HostWData;
    logic                HostGnt, HostValid;
    logic [N-1:0]        HostRData;
    logic [I-1:0]        RamAddr;
    logic                RamWe;
    logic [N-1:0]        RamWData;
    logic [N-1:0]        RamRData;

    logic [7:0] mem [256];
    logic       bdWe;
    logic [7:0] bdAddr, bdData;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] seenAddr [R];
    logic [R-1:0] seenWe;
    int stallHigh;
    logic stallLow;

    always #5 clk = ~clk;

    vmem_controller #(.I(I), .N(N), .R(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemReqM   (MemReqM),
        .MemWriteM (MemWriteM),
        .AddressM  (AddressM),
        .WriteDataM(WriteDataM),
        .ReadData  (ReadData),
        .StallM    (StallM),
        .HostReq   (HostReq),
        .HostWe    (HostWe),
        .HostAddr  (HostAddr),
        .HostWData (HostWData),
        .HostGnt   (HostGnt),
        .HostRData (HostRData),
        .HostValid (HostValid),
        .RamAddr   (RamAddr),
        .RamWe     (RamWe),
        .RamWData  (RamWData),
        .RamRData  (RamRData)
    );

    always @(posedge clk) begin
        if (bdWe)       mem[bdAddr] <= bdData;
        else if (RamWe) mem[RamAddr[7:0]] <= RamWData;
        RamRData <= mem[RamAddr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bdAddr = a;
        bdData = d;
        bdWe   = 1'b1;
        @(negedge clk);
        bdWe   = 1'b0;
    endtask

    // Called at a negedge with the controller in IDLE; returns at the negedge after DONE.
    task automatic runVec(input logic we, input logic [31:0] addr, input logic [47:0] wd);
        MemReqM    = 1'b1;
        MemWriteM  = we;
        AddressM   = addr;
        WriteDataM = wd;
        stallHigh  = 0;
        stallLow   = 1'b0;
        seenWe     = '0;
        for (int c = 0; c <= R + 2; c++) begin
            #1;
            if (c <= R + 1 && StallM) stallHigh++;
            if (c >= 1 && c <= R) begin
                seenAddr[c-1] = RamAddr;
                seenWe[c-1]   = RamWe;
            end
            if (c == R + 2) begin
                stallLow = !StallM;
                MemReqM  = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int gntC, validC, validCnt;
        int d1, d2, g1, g2, v1;
        logic [7:0] r1;

        reset = 1'b1; MemReqM = 0; MemWriteM = 0; AddressM = '0; WriteDataM = '0;
        HostReq = 0; HostWe = 0; HostAddr = '0; HostWData = '0;
        bdWe = 0; bdAddr = '0; bdData = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ramwe", RamWe, 0);
        check("rst_hostgnt", HostGnt, 0);
        check("rst_hostvalid", HostValid, 0);
        check("rst_readdata", ReadData, 0);
        check("rst_ramaddr", RamAddr, 0);
        check("rst_hostrdata", HostRData, 0);
        check("rst_stall_lo", StallM, 0);
        MemReqM = 1'b1;
        #1;
        check("rst_stall_hi", StallM, 1);
        MemReqM = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        poke(8'hFD, 8'hA1); poke(8'hFE, 8'hA2); poke(8'hFF, 8'hA3);
        poke(8'h00, 8'hA4); poke(8'h01, 8'hA5); poke(8'h02, 8'hA6);
        for (int k = 0; k < R; k++) poke(8'h30 + 8'(k), 8'hEE);

        runVec(1'b1, 32'h10, 48'h060504030201);
        check("st_stall_cycles", stallHigh, 8);
        check("st_stall_release", stallLow, 1);
        check("st_ramwe", seenWe, 6'h3F);
        check("st_addr0", seenAddr[0], 32'h10);
        check("st_addr5", seenAddr[5], 32'h15);
        check("st_mem", {mem[8'h15], mem[8'h14], mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]},
              48'h060504030201);

        runVec(1'b0, 32'h10, 48'h0);
        check("ld_readdata", ReadData, 48'h060504030201);
        check("ld_ramwe", seenWe, 6'h00);
        check("ld_stall_cycles", stallHigh, 8);

        runVec(1'b0, 32'hFFFF_FFFD, 48'h0);
        check("wrap_addr0", seenAddr[0], 32'hFFFF_FFFD);
        check("wrap_addr1", seenAddr[1], 32'hFFFF_FFFE);
        check("wrap_addr2", seenAddr[2], 32'hFFFF_FFFF);
        check("wrap_addr3", seenAddr[3], 32'h0000_0000);
        check("wrap_addr4", seenAddr[4], 32'h0000_0001);
        check("wrap_addr5", seenAddr[5], 32'h0000_0002);
        check("wrap_readdata", ReadData, 48'hA6A5A4A3A2A1);

        runVec(1'b1, 32'h20, 48'h262524232221);
        check("st_keeps_readdata", ReadData, 48'hA6A5A4A3A2A1);
        check("st2_mem20", mem[8'h20], 8'h21);
        check("st2_mem25", mem[8'h25], 8'h26);

        // host write, then host read of the same byte
        for (int pass = 0; pass < 2; pass++) begin
            HostReq = 1'b1; HostWe = (pass == 0); HostAddr = 32'h40; HostWData = 8'hAB;
            gntC = -1; validC = -1; validCnt = 0; r1 = '0;
            for (int c = 0; c < 6; c++) begin
                #1;
                if (HostGnt) begin
                    gntC = c;
                    check(pass == 0 ? "hw_ramwe" : "hr_ramwe", RamWe, (pass == 0));
                    check(pass == 0 ? "hw_ramaddr" : "hr_ramaddr", RamAddr, 32'h40);
                    HostReq = 1'b0;
                end
                if (HostValid) begin
                    validC = c; validCnt++; r1 = HostRData;
                end
                @(negedge clk);
            end
            if (pass == 0) begin
                check("hw_gnt_cycle", gntC, 1);
                check("hw_no_valid", validCnt, 0);
                check("hw_mem40", mem[8'h40], 8'hAB);
            end else begin
                check("hr_gnt_cycle", gntC, 1);
                check("hr_valid_cycle", validC, 2);
                check("hr_valid_count", validCnt, 1);
                check("hr_rdata", r1, 8'hAB);
            end
        end

        // simultaneous requests straight out of reset, then a continuous CPU stream
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        MemReqM = 1'b1; MemWriteM = 1'b0; AddressM = 32'h10; WriteDataM = '0;
        HostReq = 1'b1; HostWe = 1'b0; HostAddr = 32'h40;
        d1 = -1; d2 = -1; g1 = -1; g2 = -1; v1 = -1; r1 = '0;
        for (int c = 0; c < 26; c++) begin
            #1;
            if (MemReqM && !StallM) begin
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
            end
            if (HostGnt) begin
                if (g1 < 0) g1 = c; else if (g2 < 0) g2 = c;
                HostReq = 1'b0;
            end
            if (HostValid && v1 < 0) begin
                v1 = c; r1 = HostRData; HostReq = 1'b1;
            end
            if (c == 23) MemReqM = 1'b0;
            @(negedge clk);
        end
        HostReq = 1'b0;
        check("arb_done1", d1, 8);
        check("arb_host_gnt1", g1, 10);
        check("arb_host_valid1", v1, 11);
        check("arb_host_rdata", r1, 8'hAB);
        check("arb_done2", d2, 20);
        check("arb_host_gnt2", g2, 22);
        check("arb_readdata", ReadData, 48'h060504030201);

        // CPU request arriving during HOST_RSP
        HostReq = 1'b1; HostWe = 1'b0; HostAddr = 32'h40;
        d1 = -1;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (HostGnt) HostReq = 1'b0;
            if (c == 2) begin
                check("rsp_valid", HostValid, 1);
                MemReqM = 1'b1; MemWriteM = 1'b0; AddressM = 32'h20;
                #1;
                check("rsp_stall_now", StallM, 1);
            end
            if (c == 3) begin
                check("rsp_idle_stall", StallM, 1);
                check("rsp_idle_noaccess", {RamWe, RamAddr}, 33'h0);
            end
            if (c == 4) check("rsp_vec_addr0", RamAddr, 32'h20);
            if (c >= 3 && MemReqM && !StallM && d1 < 0) begin
                d1 = c;
                MemReqM = 1'b0;
            end
            @(negedge clk);
        end
        check("rsp_done_cycle", d1, 11);
        check("rsp_readdata", ReadData, 48'h262524232221);

        // reset during lane 3 of a store
        MemReqM = 1'b1; MemWriteM = 1'b1; AddressM = 32'h30; WriteDataM = 48'h161514131211;
        repeat (4) @(negedge clk);
        #1;
        check("abort_lane3_addr", RamAddr, 32'h33);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("abort_ramwe", RamWe, 0);
        check("abort_ramaddr", RamAddr, 0);
        check("abort_readdata", ReadData, 0);
        check("abort_hostvalid", HostValid, 0);
        check("abort_hostgnt", HostGnt, 0);
        check("abort_stall", StallM, 1);
        MemReqM = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        check("abort_mem_lo", {mem[8'h32], mem[8'h31], mem[8'h30]}, 24'h131211);
        check("abort_mem_hi", {mem[8'h35], mem[8'h34], mem[8'h33]}, 24'hEEEEEE);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vmem_controller.md
# vmem_controller

Vector memory controller between the pipeline's MEMORY stage and a single-port, byte-wide data RAM. It serializes each R-lane vector load or store into R byte accesses and freezes the pipeline while it runs. It also arbitrates the RAM fairly between the CPU and a host loader port, which handles scalar byte reads and writes.

## Interface
Parameters:
- I, 32, address width
- N, 8, lane and RAM data width
- R, 6, lane count

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset  in  1  synchronous, active-high
- MemReqM  in  1  a vector memory instruction is in the MEMORY stage
- MemWriteM  in  1  1 = store, 0 = load; valid while MemReqM
- AddressM  in  I  base byte address of lane 0
- WriteDataM  in  [R][N]  store data, lane k at byte AddressM+k
- ReadData  out  [R][N]  assembled load data, to the MEM/WB register
- StallM  out  1  freeze all pipeline registers
- HostReq  in  1  host access request, held until HostGnt
- HostWe  in  1  host write enable
- HostAddr  in  I  host byte address
- HostWData  in  N  host write data
- HostGnt  out  1  one-cycle pulse; the host access issues this cycle
- HostRData  out  N  host read data
- HostValid  out  1  one-cycle pulse; HostRData is valid
- RamAddr  out  I  RAM address
- RamWe  out  1  RAM write enable
- RamWData  out  N  RAM write data
- RamRData  in  N  RAM read data, one cycle after the address

## Operation
- States:
  - IDLE: arbitrate; no RAM access.
  - VEC: issue lane k, k = 0..R-1.
  - VEC_LAST: capture the final load byte.
  - DONE: one-cycle release of the pipeline.
  - HOST: issue the host access.
  - HOST_RSP: return host read data.
- IDLE arbitration:
  - Only MemReqM pending -> VEC.
  - Only HostReq pending -> HOST.
  - Both pending -> the requester not granted last (`last_grant` flag).
  - `last_grant` resets to HOST, so the CPU wins first.
  - `last_grant` updates on every IDLE grant.
- VEC, lane counter k:
  - RamAddr = AddressM + k, truncated to I bits so the address wraps modulo 2^I.
  - Store: RamWe = 1 and RamWData = WriteDataM[k].
  - Load: RamWe = 0; RamRData is captured into ReadData[k-1] when k>0.
  - After k = R-1 -> VEC_LAST.
- VEC_LAST:
  - Load: capture ReadData[R-1].
  - Store: idle cycle, kept so loads and stores have identical latency.
  - Next state is DONE.
- DONE: StallM = 0 so the pipeline advances past the instruction. No new grant this cycle, even if MemReqM is still high. Next state is IDLE.
- HOST:
  - HostGnt = 1; drive RamAddr = HostAddr and RamWe = HostWe.
  - Write -> IDLE; read -> HOST_RSP.
- HOST_RSP: HostRData = RamRData, HostValid = 1; next state is IDLE.
- StallM = MemReqM && state != DONE. It is combinational, so a CPU request seen in IDLE or during a host access stalls the same cycle.
- ReadData holds its value between loads. Stores never modify ReadData.
- Lanes not yet captured keep their old values until overwritten.
- Inputs are sampled each cycle; the frozen pipeline keeps MemReqM, AddressM and WriteDataM stable during VEC.

## Timing
- Vector op, CPU request granted in IDLE at cycle t:
  - VEC occupies t+1..t+R; VEC_LAST is t+R+1; DONE is t+R+2.
  - StallM is high t..t+R+1 and low at t+R+2.
  - ReadData is complete from cycle t+R+2.
- Host write granted at t: HostGnt and RamWe at t+1; back in IDLE at t+2.
- Host read granted at t: HostGnt at t+1; HostValid at t+2; back in IDLE at t+3.
- Reset values:
  - State is IDLE and `last_grant` is HOST.
  - ReadData, HostRData and RamAddr are 0.
  - RamWe, HostGnt and HostValid are 0.
  - StallM = MemReqM (combinational).
- Reset mid-operation:
  - The controller aborts at the next edge and no RAM write occurs after reset.
  - Lanes already stored remain in RAM; this partial store is accepted behaviour.
  - No HostValid is issued for an aborted host read.
- Back-to-back CPU ops:
  - The next request is seen in the IDLE cycle after DONE.
  - A pending host request wins that IDLE cycle, because `last_grant` is CPU.

## Structure
- Package `vmem_pkg`:
  - `vmem_state_t` enum, holding the six states.
  - `grant_t` enum {GNT_CPU, GNT_HOST}.
  - Default constants for I, N and R.
- One sub-module, `rr_arbiter2`: a two-requester round-robin arbiter holding `last_grant`. It updates only on an enable from IDLE.
- The lane counter, address adder, FSM and capture registers live in `vmem_controller`.

## Test plan
- Store then load, both at AddressM=0x10, with WriteDataM = {0x06,0x05,0x04,0x03,0x02,0x01} (lane 5..0):
  - RAM 0x10..0x15 = 01..06.
  - The load returns identical ReadData.
  - StallM is high for 8 cycles, then low for 1.
- Wrap-around: load at AddressM = 0xFFFFFFFD -> RamAddr sequence FFFFFFFD, FFFFFFFE, FFFFFFFF, 0, 1, 2.
- MemReqM and HostReq both rise in the same IDLE cycle after reset:
  - The CPU is served first.
  - HostGnt follows at DONE+2.
  - During a continuous CPU request stream, host and CPU grants alternate.
- Host write 0xAB to 0x40, then host read 0x40 -> HostValid pulse with HostRData = 0xAB, exactly 2 cycles after grant.
- A CPU request arriving during HOST_RSP -> StallM high immediately; VEC starts after returning to IDLE.
- Reset asserted during VEC lane 3 of a store:
  - Lanes 0..2 are written; lanes 3..5 are not.
  - All outputs read reset values on the next cycle.
